// File: rtl/dac_write_seq_if.sv
// Request channel into the DAC write sequencer: one sample per valid/ready handshake.
// Latency: none (wires only).
// Backpressure: req_ready is driven by the sequencer and stays low while a write is in flight.
//
// Signals:
//   req_valid  sample request
//   req_data   8-bit DAC code
//   req_ch     channel select, 0 = A, 1 = B
//   req_ready  sequencer idle and able to accept
interface dac_write_seq_if;
    logic       req_valid;
    logic [7:0] req_data;
    logic       req_ch;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_ch,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_ch,
        output req_ready
    );
endinterface

// File: rtl/dac_write_seq.sv
// Bus-write sequencer for an 8-bit parallel dual-channel DAC: one WRn pulse per accepted sample.
// Latency: accept to next ready = SETUP+WR+HOLD(+LDAC)+GAP cycles; done pulses on the first idle cycle.
// Backpressure: req_ready is low from accept until back in IDLE; valid is ignored meanwhile.
//
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   bus (slave)     req_valid / req_data / req_ch in, req_ready out (combinational, state==IDLE)
//   dac_csn/wrn     chip select and write strobe, active low, registered
//   dac_a_b, dac_d  channel select and data bus, hold the last written sample while idle
//   dac_ldacn       load strobe, active low
//   busy, done      busy = not idle; done = one-cycle pulse on return to IDLE
//
// Optional feature macro: DAC_WR_SYNC_LDAC_EN
//   defined     : dac_ldacn idles high and pulses low for LDAC_CYC cycles after every
//                 channel-B write, so both channels update together.
//   not defined : dac_ldacn is tied low (transparent update) and there is no LDAC state.
module dac_write_seq #(
    parameter int SETUP_CYC = 20,
    parameter int WR_CYC    = 50,
    parameter int HOLD_CYC  = 30,
    parameter int GAP_CYC   = 200,
    parameter int LDAC_CYC  = 10,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dac_write_seq_if.slave        bus,
    output logic                  dac_csn,
    output logic                  dac_wrn,
    output logic                  dac_a_b,
    output logic                  dac_ldacn,
    output logic [7:0]            dac_d,
    output logic                  busy,
    output logic                  done
);

    // A zero duration is stretched to one cycle so no state is ever skipped.
    // cnt runs 0..N-1, so each state compares against N-1.
    localparam int SETUP_EFF = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
    localparam int WR_EFF    = (WR_CYC    < 1) ? 1 : WR_CYC;
    localparam int HOLD_EFF  = (HOLD_CYC  < 1) ? 1 : HOLD_CYC;
    localparam int GAP_EFF   = (GAP_CYC   < 1) ? 1 : GAP_CYC;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_EFF - 1);
    localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_EFF - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_EFF - 1);
`ifdef DAC_WR_SYNC_LDAC_EN
    localparam int               LDAC_EFF   = (LDAC_CYC < 1) ? 1 : LDAC_CYC;
    localparam logic [CNT_W-1:0] LDAC_LAST  = CNT_W'(LDAC_EFF - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_WRITE = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
`ifdef DAC_WR_SYNC_LDAC_EN
        , S_LDAC = 3'd5
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Ready is combinational off the state register; reset forces IDLE, so it reads 1 in reset.
    assign bus.req_ready = (state == S_IDLE);

`ifndef DAC_WR_SYNC_LDAC_EN
    assign dac_ldacn = 1'b0;
`endif

    // All bus outputs are updated on the same edge as the state change, so each
    // output reflects the state it belongs to with no combinational decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            dac_csn <= 1'b1;
            dac_wrn <= 1'b1;
            dac_a_b <= 1'b0;
            dac_d   <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef DAC_WR_SYNC_LDAC_EN
            dac_ldacn <= 1'b1;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // dac_d/dac_a_b double as the latched sample, so later input
                    // changes cannot disturb a write in progress.
                    if (bus.req_valid) begin
                        state   <= S_SETUP;
                        cnt     <= '0;
                        dac_d   <= bus.req_data;
                        dac_a_b <= bus.req_ch;
                        dac_csn <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state   <= S_WRITE;
                        cnt     <= '0;
                        dac_wrn <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (cnt == WR_LAST) begin
                        state   <= S_HOLD;
                        cnt     <= '0;
                        dac_wrn <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt     <= '0;
                        dac_csn <= 1'b1;
`ifdef DAC_WR_SYNC_LDAC_EN
                        // Only a channel-B write triggers the joint load of both channels.
                        if (dac_a_b) begin
                            state     <= S_LDAC;
                            dac_ldacn <= 1'b0;
                        end else begin
                            state <= S_GAP;
                        end
`else
                        state <= S_GAP;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef DAC_WR_SYNC_LDAC_EN
                S_LDAC: begin
                    if (cnt == LDAC_LAST) begin
                        state     <= S_GAP;
                        cnt       <= '0;
                        dac_ldacn <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    dac_csn <= 1'b1;
                    dac_wrn <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_write_seq.sv
// Directed bench for dac_write_seq with SETUP=2 WR=3 HOLD=2 GAP=4 LDAC=2, plus a SETUP_CYC=0 instance.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Sample k is the view after the k-th rising edge following the accept edge (sample 0 = just after accept).
module tb_dac_write_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

`ifdef DAC_WR_SYNC_LDAC_EN
    localparam logic LDACN_IDLE = 1'b1;
`else
    localparam logic LDACN_IDLE = 1'b0;
`endif

    dac_write_seq_if bus ();
    dac_write_seq_if bus0 ();

    logic       csn, wrn, a_b, ldacn, busy, done;
    logic [7:0] d;
    logic       csn0, wrn0, a_b0, ldacn0, busy0, done0;
    logic [7:0] d0;

    dac_write_seq #(
        .SETUP_CYC(2), .WR_CYC(3), .HOLD_CYC(2), .GAP_CYC(4), .LDAC_CYC(2), .CNT_W(8)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(bus),
        .dac_csn(csn), .dac_wrn(wrn), .dac_a_b(a_b), .dac_ldacn(ldacn),
        .dac_d(d), .busy(busy), .done(done)
    );

    dac_write_seq #(
        .SETUP_CYC(0), .WR_CYC(3), .HOLD_CYC(2), .GAP_CYC(4), .LDAC_CYC(2), .CNT_W(8)
    ) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .dac_csn(csn0), .dac_wrn(wrn0), .dac_a_b(a_b0), .dac_ldacn(ldacn0),
        .dac_d(d0), .busy(busy0), .done(done0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and advances to just after the next edge (the accept edge when idle).
    task automatic start(input logic [7:0] data, input logic ch);
        bus.req_valid = 1'b1;
        bus.req_data  = data;
        bus.req_ch    = ch;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_data = 8'h00; bus.req_ch = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_data = 8'h00; bus0.req_ch = 1'b0;
        #2;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready_in_reset actual=%b expected=1", bus.req_ready);
        end
        tick(); tick();
        @(negedge clk) rst = 1'b1;
        tick();
        checks++; if (csn !== 1'b1) begin failures++; $display("FAIL reset_csn actual=%b expected=1", csn); end
        checks++; if (wrn !== 1'b1) begin failures++; $display("FAIL reset_wrn actual=%b expected=1", wrn); end
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_d actual=%h expected=00", d); end
        checks++; if (a_b !== 1'b0) begin failures++; $display("FAIL reset_a_b actual=%b expected=0", a_b); end
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready actual=%b expected=1", bus.req_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b expected=0", done); end
        checks++; if (ldacn !== LDACN_IDLE) begin failures++; $display("FAIL reset_ldacn actual=%b expected=%b", ldacn, LDACN_IDLE); end
    endtask

    task automatic test_reset_abort();
        int low_cnt;
        start(8'h55, 1'b0);
        bus.req_valid = 1'b0;
        tick(); tick(); tick();   // sample 3: inside WRITE
        checks++;
        if (wrn !== 1'b0) begin failures++; $display("FAIL abort_pre_wrn actual=%b expected=0", wrn); end
        #2 rst = 1'b0;
        #1;                       // still before the next clock edge
        checks++; if (wrn !== 1'b1) begin failures++; $display("FAIL abort_wrn actual=%b expected=1", wrn); end
        checks++; if (csn !== 1'b1) begin failures++; $display("FAIL abort_csn actual=%b expected=1", csn); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy actual=%b expected=0", busy); end
        @(negedge clk) rst = 1'b1;
        low_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (csn !== 1'b1 || wrn !== 1'b1) low_cnt++;
        end
        checks++;
        if (low_cnt != 0) begin failures++; $display("FAIL abort_no_retry strobe_cycles=%0d expected=0", low_cnt); end
    endtask

    task automatic test_single_write();
        int csn_low, wrn_low, first_wrn, d_bad, done_idx, done_cnt;
        csn_low = 0; wrn_low = 0; first_wrn = -1; d_bad = 0; done_idx = -1; done_cnt = 0;
        start(8'hA5, 1'b0);
        bus.req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy actual=%b expected=1", busy); end
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL single_ready_low actual=%b expected=0", bus.req_ready); end
        for (int k = 0; k < 14; k++) begin
            if (k > 0) tick();
            if (csn === 1'b0) begin
                csn_low++;
                if (d !== 8'hA5 || a_b !== 1'b0) d_bad++;
            end
            if (wrn === 1'b0) begin
                wrn_low++;
                if (first_wrn < 0) first_wrn = k;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = k;
            end
        end
        checks++; if (csn_low != 7) begin failures++; $display("FAIL single_csn_low actual=%0d expected=7", csn_low); end
        checks++; if (wrn_low != 3) begin failures++; $display("FAIL single_wrn_low actual=%0d expected=3", wrn_low); end
        checks++; if (first_wrn != 2) begin failures++; $display("FAIL single_wrn_start actual=%0d expected=2", first_wrn); end
        checks++; if (d_bad != 0) begin failures++; $display("FAIL single_data bad_cycles=%0d expected=0", d_bad); end
        checks++; if (done_idx != 11) begin failures++; $display("FAIL single_done_at actual=%0d expected=11", done_idx); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL single_done_width actual=%0d expected=1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        int falls, min_gap, run, d_bad;
        logic prev_wrn, prev_csn, seen_low;
        falls = 0; min_gap = 1000; run = 0; d_bad = 0;
        prev_wrn = 1'b1; prev_csn = 1'b1; seen_low = 1'b0;
        start(8'h10, 1'b0);
        bus.req_data = 8'h20;     // valid stays high for the second sample
        for (int k = 0; k < 24; k++) begin
            if (k > 0) tick();
            if (prev_wrn === 1'b1 && wrn === 1'b0) falls++;
            if (csn === 1'b1) run++;
            else begin
                if (seen_low && prev_csn === 1'b1 && run < min_gap) min_gap = run;
                run = 0;
                seen_low = 1'b1;
            end
            if (k < 7 && d !== 8'h10) d_bad++;
            if (k == 11) begin
                checks++;
                if (done !== 1'b1 || bus.req_ready !== 1'b1) begin
                    failures++; $display("FAIL b2b_accept_on_done done=%b ready=%b expected=1,1", done, bus.req_ready);
                end
            end
            if (k == 12) begin
                checks++;
                if (csn !== 1'b0 || d !== 8'h20) begin
                    failures++; $display("FAIL b2b_second_accept csn=%b d=%h expected=0,20", csn, d);
                end
                bus.req_valid = 1'b0;
            end
            prev_wrn = wrn;
            prev_csn = csn;
        end
        checks++; if (falls != 2) begin failures++; $display("FAIL b2b_wr_pulses actual=%0d expected=2", falls); end
        checks++; if (min_gap < 4) begin failures++; $display("FAIL b2b_min_gap actual=%0d expected>=4", min_gap); end
        checks++; if (d_bad != 0) begin failures++; $display("FAIL b2b_first_data bad_cycles=%0d expected=0", d_bad); end
    endtask

    task automatic test_data_hold();
        int bad;
        logic got_done;
        bad = 0; got_done = 1'b0;
        start(8'h3C, 1'b1);
        bus.req_valid = 1'b0;
        for (int k = 0; k < 20 && !got_done; k++) begin
            if (k > 0) tick();
            if (k == 2) begin
                bus.req_data = 8'hFF;
                bus.req_ch   = 1'b0;
            end
            if (d !== 8'h3C || a_b !== 1'b1) bad++;
            if (done === 1'b1) got_done = 1'b1;
        end
        checks++; if (!got_done) begin failures++; $display("FAIL hold_done_timeout done=%b expected=1", done); end
        tick(); tick();
        if (d !== 8'h3C || a_b !== 1'b1) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL hold_data bad_cycles=%0d expected=0 d=%h", bad, d); end
    endtask

    task automatic test_ldac();
        int low0, low1, first1, csn_bad, done1;
        low0 = 0; low1 = 0; first1 = -1; csn_bad = 0; done1 = -1;
        start(8'h11, 1'b0);
        bus.req_valid = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) tick();
            if (ldacn !== LDACN_IDLE) low0++;
        end
        start(8'h22, 1'b1);
        bus.req_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) tick();
            if (ldacn === 1'b0) begin
                low1++;
                if (first1 < 0) first1 = k;
                if (csn !== 1'b1) csn_bad++;
            end
            if (done === 1'b1 && done1 < 0) done1 = k;
        end
`ifdef DAC_WR_SYNC_LDAC_EN
        checks++; if (low0 != 0) begin failures++; $display("FAIL ldac_cha_pulse low_cycles=%0d expected=0", low0); end
        checks++; if (low1 != 2) begin failures++; $display("FAIL ldac_chb_width actual=%0d expected=2", low1); end
        checks++; if (first1 != 7) begin failures++; $display("FAIL ldac_chb_start actual=%0d expected=7", first1); end
        checks++; if (csn_bad != 0) begin failures++; $display("FAIL ldac_csn_high bad_cycles=%0d expected=0", csn_bad); end
        checks++; if (done1 != 13) begin failures++; $display("FAIL ldac_done_at actual=%0d expected=13", done1); end
`else
        checks++; if (low0 != 0) begin failures++; $display("FAIL ldacn_const_cha nonzero_cycles=%0d expected=0", low0); end
        checks++; if (low1 != 15) begin failures++; $display("FAIL ldacn_const_chb low_cycles=%0d expected=15", low1); end
        checks++; if (done1 != 11) begin failures++; $display("FAIL ldac_done_at actual=%0d expected=11", done1); end
`endif
    endtask

    task automatic test_setup_zero();
        logic got_done;
        got_done = 1'b0;
        bus0.req_valid = 1'b1;
        bus0.req_data  = 8'h5A;
        bus0.req_ch    = 1'b0;
        tick();
        bus0.req_valid = 1'b0;
        checks++; if (csn0 !== 1'b0 || wrn0 !== 1'b1) begin failures++; $display("FAIL setup0_sample0 csn=%b wrn=%b expected=0,1", csn0, wrn0); end
        tick();
        checks++; if (wrn0 !== 1'b0) begin failures++; $display("FAIL setup0_wrn_fall actual=%b expected=0", wrn0); end
        checks++; if (d0 !== 8'h5A) begin failures++; $display("FAIL setup0_data actual=%h expected=5a", d0); end
        for (int k = 0; k < 15 && !got_done; k++) begin
            tick();
            if (done0 === 1'b1) got_done = 1'b1;
        end
        checks++; if (!got_done || bus0.req_ready !== 1'b1) begin failures++; $display("FAIL setup0_done done_seen=%b ready=%b expected=1,1", got_done, bus0.req_ready); end
    endtask

    initial begin
        test_reset();
        test_reset_abort();
        test_single_write();
        test_back_to_back();
        test_data_hold();
        test_ldac();
        test_setup_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
